test_trace: RTL
===============

Name: test_trace

Overview:
- Parametrised debug probe placed beside the computer core; generalises the single test_sel/test_out tap.
- Selects one of CHANNELS test words into a registered live output.
- Records the selected word into a circular trace buffer with pre- and post-trigger capture.
- The bench or host reads the trace back, addressed oldest-first.

Parameters:
WIDTH, 32, bits per test channel and per trace sample
CHANNELS, 16, number of test channels on test_in
SEL_W, 4, width of test_sel (2**SEL_W >= CHANNELS)
AW, 6, trace address width; DEPTH = 2**AW samples

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
test_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
test_sel  in  SEL_W  channel select
test_out  out  WIDTH  registered selected channel (live tap)
arm  in  1  one-cycle pulse: start or restart a capture
trig_mode  in  2  0 immediate, 1 match trig_value, 2 any change, 3 never (free-run)
trig_value  in  WIDTH  match value for mode 1
post_count  in  AW  samples to record after the trigger sample
busy  out  1  state is ARMED or POST
done  out  1  state is DONE
fill  out  AW+1  valid samples in buffer, saturates at DEPTH
trig_idx  out  AW  oldest-relative index of the trigger sample, valid when done
rd_addr  in  AW  oldest-relative read index
rd_data  out  WIDTH  registered buffer read data

Behaviour:
- Reset values: test_out=0, state=IDLE, busy=0, done=0, fill=0, trig_idx=0, rd_data=0, wr_ptr=0. Buffer RAM is not reset. Reset overrides arm.
- Live tap: every edge, test_out <= test_in[test_sel] if test_sel<CHANNELS, else 0. Latency 1 cycle in all states.
- States: IDLE(0), ARMED(1), POST(2), DONE(3).
- arm=1 in any state, including ARMED or POST, forces on that edge:
  - state->ARMED, wr_ptr=0, fill=0, prev_valid=0;
  - trig_mode, trig_value and post_count latched into internal registers. Later changes to these inputs are ignored until the next arm.
  - No sample is written on the arm edge.
- Write rule: every edge in ARMED or POST (arm=0):
  - mem[wr_ptr] <= test_out (the current registered value);
  - wr_ptr <= wr_ptr+1 mod DEPTH;
  - fill <= min(fill+1, DEPTH).
- Trigger: evaluated in ARMED on the sample being written.
  - Mode 0: always hits.
  - Mode 1: hits when the sample equals trig_value.
  - Mode 2: hits when prev_valid and the sample differs from the previous sample. The first sample after arm never hits.
  - Mode 3: never hits; the buffer wraps indefinitely.
- On hit, the trigger sample is written and its absolute index is latched. Next state: DONE if latched post_count=0, else POST with post_left=post_count.
- POST: each write decrements post_left; the write made with post_left=1 moves the state to DONE.
- DONE: no writes; buffer, fill and wr_ptr frozen. trig_idx = (trig_abs - oldest) mod DEPTH, updated on the DONE entry edge.
- Oldest index: 0 if fill<DEPTH, else wr_ptr.
- Readback: rd_data <= mem[(oldest + rd_addr) mod DEPTH] every edge in any state; 1-cycle latency.
  - rd_addr >= fill returns stale or undefined RAM; the bench must not check it.
- In ARMED/POST, reading the slot being written returns old data (read-before-write).
- test_sel changes mid-capture simply change the recorded stream. In mode 2 such a change counts as a change.

Test Plan:
- Reset, then drive channel 2 = 0x0000_1234, test_sel=2 -> test_out=0x1234 one edge later; test_sel=15 with CHANNELS=12 -> test_out=0.
- Channel 0 counts up 1 per cycle from 0, arm with mode 0, post_count=5 -> done after 6 writes, fill=6, trig_idx=0, rd_data at rd_addr 0..5 = consecutive values.
- Same counter, mode 1, trig_value=100, post_count=10 -> buffer wraps, fill=64, trig_idx=53, rd_addr 53 reads 100, rd_addr 63 reads 110, rd_addr 0 reads 47.
- Mode 2 on a constant 0xAA channel, step to 0x55 after 20 cycles, post_count=0 -> done on the first 0x55 sample, trig_idx=fill-1, no trigger on the first sample.
- Re-arm while in POST, and separately assert reset mid-ARMED -> fill returns to 0 and state goes to ARMED or IDLE respectively on that edge; no further writes occur after reset.
- Mode 3 free-run for 200 cycles -> busy stays 1, done stays 0, fill saturates at 64; arm with mode 0 then restarts a capture.

Source files
------------

// File: rtl/test_trace.sv
// Debug probe: registered live tap of one of CHANNELS test words, plus a circular
// trace buffer with pre/post-trigger capture, read back oldest-first.
module test_trace #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4,
    parameter int AW       = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] test_in,
    input  logic [SEL_W-1:0]          test_sel,
    output logic [WIDTH-1:0]          test_out,
    input  logic                      arm,
    input  logic [1:0]                trig_mode,
    input  logic [WIDTH-1:0]          trig_value,
    input  logic [AW-1:0]             post_count,
    output logic                      busy,
    output logic                      done,
    output logic [AW:0]               fill,
    output logic [AW-1:0]             trig_idx,
    input  logic [AW-1:0]             rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] POST  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] value_q;
    logic [AW-1:0]    post_q;
    logic [AW-1:0]    post_left;
    logic [AW-1:0]    wr_ptr;
    logic             prev_valid;
    logic [WIDTH-1:0] prev_sample;
    logic [AW-1:0]    trig_abs;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] sel_word;
    logic             wr_en;
    logic             hit;
    logic             enter_done;
    logic [AW:0]      fill_nx;
    logic [AW-1:0]    wr_ptr_nx;
    logic [AW-1:0]    trig_abs_nx;
    logic [AW-1:0]    oldest;
    logic [AW-1:0]    oldest_nx;
    logic [AW-1:0]    rd_idx;

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (test_sel == SEL_W'(k)) sel_word = test_in[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        hit = 1'b0;
        if (state == ARMED) begin
            case (mode_q)
                2'd0:    hit = 1'b1;
                2'd1:    hit = (test_out == value_q);
                2'd2:    hit = prev_valid && (test_out != prev_sample);
                default: hit = 1'b0;
            endcase
        end
    end

    assign wr_en       = ((state == ARMED) || (state == POST)) && !arm && !reset;
    assign fill_nx     = (wr_en && !fill[AW]) ? fill + 1'b1 : fill;
    assign wr_ptr_nx   = wr_en ? wr_ptr + 1'b1 : wr_ptr;
    assign trig_abs_nx = (wr_en && hit) ? wr_ptr : trig_abs;
    assign oldest      = fill[AW] ? wr_ptr : '0;
    assign oldest_nx   = fill_nx[AW] ? wr_ptr_nx : '0;
    assign enter_done  = wr_en && ((hit && (post_q == '0)) ||
                                   ((state == POST) && (post_left == AW'(1))));
    assign rd_idx      = oldest + rd_addr;

    assign busy = (state == ARMED) || (state == POST);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            test_out    <= '0;
            state       <= IDLE;
            mode_q      <= 2'd0;
            value_q     <= '0;
            post_q      <= '0;
            post_left   <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            prev_valid  <= 1'b0;
            prev_sample <= '0;
            trig_abs    <= '0;
            trig_idx    <= '0;
        end else begin
            test_out <= sel_word;
            if (arm) begin
                state      <= ARMED;
                wr_ptr     <= '0;
                fill       <= '0;
                prev_valid <= 1'b0;
                mode_q     <= trig_mode;
                value_q    <= trig_value;
                post_q     <= post_count;
            end else if (wr_en) begin
                wr_ptr      <= wr_ptr_nx;
                fill        <= fill_nx;
                prev_valid  <= 1'b1;
                prev_sample <= test_out;
                if (hit) begin
                    trig_abs <= wr_ptr;
                    if (post_q == '0) begin
                        state <= DONE;
                    end else begin
                        state     <= POST;
                        post_left <= post_q;
                    end
                end else if (state == POST) begin
                    post_left <= post_left - 1'b1;
                    if (post_left == AW'(1)) state <= DONE;
                end
                // Trigger index is relative to the oldest slot as it stands after this write.
                if (enter_done) trig_idx <= trig_abs_nx - oldest_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= test_out;
    end

    // Nonblocking write above means a same-slot read returns the old word.
    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_idx];
    end

endmodule
